// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Autonomous channel-scan scheduler for the AD7811 SPI conversion engine.
// A scan starts periodically or on a software trigger. It issues one control
// word per enabled channel, in ascending channel order, over a valid/ready
// command port. It collects one in-order result per command and keeps the
// latest result per channel together with sticky new-result flags.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   cfg_enable      enable periodic scanning
//   cfg_period      scan period in clk cycles (0 = back-to-back scans)
//   cfg_ch_mask     channels included in a scan
//   cfg_ctrl_word   base control word; the channel field is replaced per channel
//   sw_trig         one-cycle request for a single scan
//   cmd_valid/ready/data   command handshake towards the engine TX FIFO
//   rsp_valid/data  in-order conversion result (no backpressure)
//   res_data        latest result per channel, ch0 in the LSBs
//   res_valid       sticky per-channel new-result flags, cleared by res_clr
//   busy            scan in progress
//   scan_done       one-cycle pulse when a scan completes normally
//   err_timeout     sticky flag: no response within RSP_TIMEOUT cycles
//   err_overrun     sticky flag: periodic tick arrived while busy
//   err_clr         clears both error flags
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
   parameter int N_CH        = 4,
   parameter int DATA_WIDTH  = 10,
   parameter int CH_LSB      = 3,
   parameter int PERIOD_W    = 24,
   parameter int RSP_TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_enable,
   input  logic [PERIOD_W-1:0]        cfg_period,
   input  logic [N_CH-1:0]            cfg_ch_mask,
   input  logic [DATA_WIDTH-1:0]      cfg_ctrl_word,
   input  logic                       sw_trig,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [DATA_WIDTH-1:0]      cmd_data,
   input  logic                       rsp_valid,
   input  logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [N_CH*DATA_WIDTH-1:0] res_data,
   output logic [N_CH-1:0]            res_valid,
   input  logic [N_CH-1:0]            res_clr,
   output logic                       busy,
   output logic                       scan_done,
   output logic                       err_timeout,
   output logic                       err_overrun,
   input  logic                       err_clr
);

   localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

   state_e                    state_q, state_d;
   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic [N_CH-1:0]           mask_q, mask_d;
   logic [PERIOD_W-1:0]       cnt_q, cnt_d;
   logic [TMO_W-1:0]          tmo_q, tmo_d;
   logic                      cmd_valid_q, cmd_valid_d;
   logic [DATA_WIDTH-1:0]     cmd_data_q, cmd_data_d;
   logic [N_CH*DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic [N_CH-1:0]           res_valid_q, res_valid_d;
   logic                      busy_q, busy_d;
   logic                      scan_done_q, scan_done_d;
   logic                      err_timeout_q, err_timeout_d;
   logic                      err_overrun_q, err_overrun_d;

   logic                      tick;
   logic                      has_next;
   logic [PTR_W-1:0]          next_ptr;
   logic [PTR_W-1:0]          first_ptr;
   logic [N_CH-1:0]           res_set;
   logic                      timeout_set;

   // Control word for a channel: base word with the channel field replaced.
   function automatic logic [DATA_WIDTH-1:0] word_for(input logic [DATA_WIDTH-1:0] base,
                                                      input logic [PTR_W-1:0]      ch);
      logic [DATA_WIDTH-1:0] w;
      w = base;
      w[CH_LSB +: PTR_W] = ch;
      return w;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      tick      = 1'b0;
      cnt_d     = cnt_q;
      has_next  = 1'b0;
      next_ptr  = '0;
      first_ptr = '0;

      // Period timer. The >= compare lets a period shortened below the
      // current count tick at once instead of waiting for a full wrap.
      if (!cfg_enable) begin
         cnt_d = '0;
      end else if (cfg_period == '0) begin
         tick = (state_q == IDLE);
      end else if (cnt_q >= cfg_period - PERIOD_W'(1)) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end

      // Descending scans leave the lowest qualifying index as the result.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(ptr_q))) begin
            has_next = 1'b1;
            next_ptr = PTR_W'(i);
         end
         if (cfg_ch_mask[i]) begin
            first_ptr = PTR_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      mask_d      = mask_q;
      tmo_d       = tmo_q;
      cmd_valid_d = cmd_valid_q;
      cmd_data_d  = cmd_data_q;
      busy_d      = busy_q;
      scan_done_d = 1'b0;
      res_data_d  = res_data_q;
      res_set     = '0;
      timeout_set = 1'b0;

      unique case (state_q)
         IDLE: begin
            if ((tick || sw_trig) && (cfg_ch_mask != '0)) begin
               state_d     = ISSUE;
               mask_d      = cfg_ch_mask;
               ptr_d       = first_ptr;
               cmd_valid_d = 1'b1;
               cmd_data_d  = word_for(cfg_ctrl_word, first_ptr);
               busy_d      = 1'b1;
            end
         end
         ISSUE: begin
            if (cmd_ready) begin
               state_d     = WAIT_RSP;
               cmd_valid_d = 1'b0;
               tmo_d       = '0;
            end
         end
         WAIT_RSP: begin
            if (rsp_valid) begin
               res_data_d[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH] = rsp_data;
               res_set[ptr_q] = 1'b1;
               if (has_next) begin
                  state_d     = ISSUE;
                  ptr_d       = next_ptr;
                  cmd_valid_d = 1'b1;
                  cmd_data_d  = word_for(cfg_ctrl_word, next_ptr);
               end else begin
                  state_d     = IDLE;
                  busy_d      = 1'b0;
                  scan_done_d = 1'b1;
               end
            end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               timeout_set = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            cmd_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase

      // Set beats clear on every sticky flag.
      res_valid_d   = (res_valid_q & ~res_clr) | res_set;
      err_timeout_d = (err_timeout_q & ~err_clr) | timeout_set;
      // A tick outside IDLE can only come from a non-zero period.
      err_overrun_d = (err_overrun_q & ~err_clr) | (tick && (state_q != IDLE));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before this edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         mask_q        <= '0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         cmd_valid_q   <= 1'b0;
         cmd_data_q    <= '0;
         // NOTE: the result store is a small flop bank, not a RAM, so it can
         // take a reset value and reads back as zero after reset.
         res_data_q    <= '0;
         res_valid_q   <= '0;
         busy_q        <= 1'b0;
         scan_done_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         mask_q        <= mask_d;
         cnt_q         <= cnt_d;
         tmo_q         <= tmo_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_data_q    <= cmd_data_d;
         res_data_q    <= res_data_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
         scan_done_q   <= scan_done_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_data    = cmd_data_q;
   assign res_data    = res_data_q;
   assign res_valid   = res_valid_q;
   assign busy        = busy_q;
   assign scan_done   = scan_done_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Directed and randomised scans against a channel-level reference model: the
// expected command stream is "base word with channel field = ch, for each set
// mask bit ascending", and the expected result store is an array written by
// every accepted response. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

   localparam int N_CH    = 4;
   localparam int DW      = 10;
   localparam int CH_LSB  = 3;
   localparam int PTR_W   = 2;
   localparam int PW      = 24;
   localparam int TMO     = 64;
   localparam int ENG_LAT = 20;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_enable;
   logic [PW-1:0]      cfg_period;
   logic [N_CH-1:0]    cfg_ch_mask;
   logic [DW-1:0]      cfg_ctrl_word;
   logic               sw_trig;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [DW-1:0]      cmd_data;
   logic               rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic [N_CH*DW-1:0] res_data;
   logic [N_CH-1:0]    res_valid;
   logic [N_CH-1:0]    res_clr;
   logic               busy;
   logic               scan_done;
   logic               err_timeout;
   logic               err_overrun;
   logic               err_clr;

   adc_scan_sequencer #(
      .N_CH(N_CH), .DATA_WIDTH(DW), .CH_LSB(CH_LSB), .PERIOD_W(PW), .RSP_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
      .cfg_ch_mask(cfg_ch_mask), .cfg_ctrl_word(cfg_ctrl_word), .sw_trig(sw_trig),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .res_data(res_data),
      .res_valid(res_valid), .res_clr(res_clr), .busy(busy), .scan_done(scan_done),
      .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model of the result store.
   logic [DW-1:0]   exp_res [N_CH];
   logic [N_CH-1:0] exp_rv;

   int eng_lat  = 0;
   int done_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_results();
      for (int ch = 0; ch < N_CH; ch++) begin
         check("res_data", res_data[ch*DW +: DW], exp_res[ch]);
      end
      check("res_valid", res_valid, exp_rv);
   endtask

   // One software-triggered scan with an in-line engine model.
   task automatic run_scan(input logic [N_CH-1:0] mask, input logic [DW-1:0] ctrl,
                           input logic [N_CH*DW-1:0] rvals, input int max_lat,
                           input int bp_cycles, input bit stray_trig, input bit clr_on_rsp);
      logic [DW-1:0] exp_cmd;
      int            wait_cnt;
      int            lat;
      cfg_ch_mask   = mask;
      cfg_ctrl_word = ctrl;
      sw_trig       = 1'b1;
      @(negedge clk);
      sw_trig     = 1'b0;
      cfg_ch_mask = ~mask;   // must not affect the scan already started
      check("busy_at_start", busy, 1'b1);
      for (int ch = 0; ch < N_CH; ch++) begin
         if (!mask[ch]) continue;
         exp_cmd = ctrl;
         exp_cmd[CH_LSB +: PTR_W] = PTR_W'(ch);
         wait_cnt = 0;
         while (!cmd_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
         end
         check("cmd_valid", cmd_valid, 1'b1);
         check("cmd_data", cmd_data, exp_cmd);
         for (int b = 0; b < bp_cycles; b++) begin
            @(negedge clk);
            check("bp_valid", cmd_valid, 1'b1);
            check("bp_data", cmd_data, exp_cmd);
         end
         cmd_ready = 1'b1;
         @(negedge clk);
         cmd_ready = 1'b0;
         check("cmd_drop", cmd_valid, 1'b0);
         lat = $urandom_range(max_lat, 0);
         for (int k = 0; k < lat; k++) begin
            sw_trig = stray_trig && (k == 0);
            @(negedge clk);
         end
         sw_trig   = 1'b0;
         rsp_valid = 1'b1;
         rsp_data  = rvals[ch*DW +: DW];
         res_clr   = clr_on_rsp ? N_CH'(1 << ch) : '0;
         @(negedge clk);
         rsp_valid   = 1'b0;
         res_clr     = '0;
         exp_res[ch] = rvals[ch*DW +: DW];
         exp_rv[ch]  = 1'b1;
      end
      check("scan_done", scan_done, 1'b1);
      check("busy_end", busy, 1'b0);
      check_results();
      @(negedge clk);
      check("scan_done_pulse", scan_done, 1'b0);
      check("idle_after", busy | cmd_valid, 1'b0);
   endtask

   // Free-running engine: always ready, answers ENG_LAT cycles after a handshake.
   task automatic run_engine(input int cycles, input int exp_gap);
      int last_done;
      last_done = -1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         rsp_valid = 1'b0;
         if (scan_done) begin
            done_cnt++;
            if (exp_gap > 0 && last_done >= 0) check("period_gap", c - last_done, exp_gap);
            last_done = c;
         end
         if (eng_lat > 0) begin
            eng_lat--;
            if (eng_lat == 0) begin
               rsp_valid  = 1'b1;
               rsp_data   = DW'($urandom);
               exp_res[0] = rsp_data;
               exp_rv[0]  = 1'b1;
            end
         end else if (cmd_valid) begin
            eng_lat = ENG_LAT;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_CH*DW-1:0] rv;
      logic [N_CH-1:0]    clr;
      int                 tmo_seen;
      bit                 saw_done;

      rst_n = 1'b0; cfg_enable = 1'b0; cfg_period = '0; cfg_ch_mask = '0;
      cfg_ctrl_word = '0; sw_trig = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
      rsp_data = '0; res_clr = '0; err_clr = 1'b0;
      for (int i = 0; i < N_CH; i++) exp_res[i] = '0;
      exp_rv = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_cmd_data", cmd_data, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_scan_done", scan_done, 1'b0);
      check("rst_errs", {err_timeout, err_overrun}, 2'b00);
      check_results();

      // Directed single-shot scan, mask 1011
      rv = {10'h108, 10'h000, 10'h102, 10'h101};
      run_scan(4'b1011, 10'h000, rv, 3, 0, 1'b0, 1'b0);

      // Mask 0 with trigger: nothing happens
      cfg_ch_mask = '0;
      sw_trig     = 1'b1;
      @(negedge clk);
      sw_trig = 1'b0;
      check("mask0_valid", cmd_valid, 1'b0);
      check("mask0_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("mask0_late", {cmd_valid, busy, scan_done}, 3'b000);

      // Backpressure for 15 cycles
      rv = {$urandom, $urandom};
      run_scan(4'b0100, 10'h3FF, rv, 3, 15, 1'b0, 1'b0);

      // res_clr coincident with the ch0 write: set wins; then a plain clear
      rv = {$urandom, $urandom};
      run_scan(4'b0001, 10'h0A5, rv, 2, 0, 1'b0, 1'b1);
      res_clr = '1;
      @(negedge clk);
      res_clr = '0;
      exp_rv  = '0;
      check("res_clr_all", res_valid, exp_rv);

      // Randomised scans with backpressure, stray triggers and random clears
      for (int n = 0; n < 8; n++) begin
         rv = {$urandom, $urandom};
         run_scan(N_CH'($urandom_range(15, 1)), DW'($urandom), rv, 6,
                  $urandom_range(3, 0), 1'($urandom), 1'b0);
         clr     = N_CH'($urandom);
         res_clr = clr;
         @(negedge clk);
         res_clr = '0;
         exp_rv  = exp_rv & ~clr;
         check("rand_clr", res_valid, exp_rv);
      end
      check("no_overrun_sw", err_overrun, 1'b0);

      // Response timeout
      cfg_ch_mask   = 4'b0001;
      cfg_ctrl_word = 10'h155;
      sw_trig       = 1'b1;
      @(negedge clk);
      sw_trig = 1'b0;
      check("tmo_cmd_valid", cmd_valid, 1'b1);
      cmd_ready = 1'b1;
      tmo_seen  = -1;
      saw_done  = 1'b0;
      for (int i = 0; i < TMO + 20; i++) begin
         @(negedge clk);
         cmd_ready = 1'b0;
         if (scan_done) saw_done = 1'b1;
         if (err_timeout) begin
            tmo_seen = i;
            break;
         end
      end
      check("timeout_latency", tmo_seen, TMO);
      check("timeout_no_done", saw_done, 1'b0);
      check("timeout_idle", busy, 1'b0);
      @(negedge clk);
      rsp_valid = 1'b1;
      rsp_data  = 10'h3AA;
      @(negedge clk);
      rsp_valid = 1'b0;
      check_results();
      check("late_rsp_no_done", scan_done, 1'b0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("timeout_clr", err_timeout, 1'b0);

      // Periodic scanning, period 200, engine latency 20
      cmd_ready   = 1'b1;
      cfg_ch_mask = 4'b0001;
      cfg_period  = PW'(200);
      cfg_enable  = 1'b1;
      done_cnt    = 0;
      run_engine(700, 200);
      check("period_done_cnt", done_cnt, 3);
      check("period_no_overrun", err_overrun, 1'b0);
      cfg_period = PW'(10);
      run_engine(40, 0);
      check("overrun_set", err_overrun, 1'b1);
      cfg_enable = 1'b0;
      run_engine(60, 0);
      @(negedge clk);
      rsp_valid = 1'b0;
      cmd_ready = 1'b0;
      check("period_drained", busy, 1'b0);
      check_results();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("overrun_clr", err_overrun, 1'b0);

      // Asynchronous reset while waiting for a response
      cfg_ch_mask = 4'b0010;
      sw_trig     = 1'b1;
      @(negedge clk);
      sw_trig   = 1'b0;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ctrl", {cmd_valid, busy, scan_done, err_timeout, err_overrun}, 5'b0);
      check("async_rst_data", res_data, '0);
      check("async_rst_valid", res_valid, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N_CH; i++) exp_res[i] = '0;
      exp_rv = '0;
      @(negedge clk);
      check("post_reset_idle", {cmd_valid, busy}, 2'b00);
      check_results();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Autonomous channel-scan scheduler for the AD7811 SPI conversion engine.
- Periodically, or on software trigger, issues one 10-bit control word per enabled channel over a valid/ready command port and collects one in-order 10-bit result per command.
- Stores the latest result per channel with sticky valid flags, and reports scan completion, response timeout and trigger overrun.
- Sits between the APB register file and the ADC engine's TX/RX FIFO interface.

Parameters:
- N_CH, 4, number of ADC channels (AD7811 has 4).
- DATA_WIDTH, 10, command/result word width.
- CH_LSB, 3, bit position of the channel field inside the control word; field width is $clog2(N_CH).
- PERIOD_W, 24, width of the scan period counter.
- RSP_TIMEOUT, 1024, max clk cycles from command handshake to response.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  enable periodic scanning
- cfg_period  in  PERIOD_W  scan period in clk cycles; 0 = continuous back-to-back
- cfg_ch_mask  in  N_CH  channels included in a scan
- cfg_ctrl_word  in  DATA_WIDTH  base control word; channel field overwritten per channel
- sw_trig  in  1  one-cycle pulse, request a single scan
- cmd_valid  out  1  command valid
- cmd_ready  in  1  engine accepts command
- cmd_data  out  DATA_WIDTH  control word
- rsp_valid  in  1  result valid (single-cycle, no backpressure)
- rsp_data  in  DATA_WIDTH  conversion result
- res_data  out  N_CH*DATA_WIDTH  latest result per channel, ch0 in LSBs
- res_valid  out  N_CH  sticky per-channel new-result flags
- res_clr  in  N_CH  clear res_valid bits
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at scan completion
- err_timeout  out  1  sticky response-timeout flag
- err_overrun  out  1  sticky flag: periodic tick while busy
- err_clr  in  1  clear both error flags

Behaviour:
- Reset: all outputs 0, res_data 0, state IDLE, period counter 0.
- Registered outputs only.
- Period timer:
  - Held at 0 while cfg_enable=0.
  - Otherwise counts 0..cfg_period-1; tick on the cycle it equals cfg_period-1, then wraps to 0.
  - cfg_period=0: tick every cycle the FSM is IDLE.
- Start condition (IDLE only): (tick | sw_trig) and cfg_ch_mask≠0.
  - Mask is latched at start; later mask changes affect only the next scan.
  - Tick and sw_trig in the same cycle give one scan.
  - Mask=0: start ignored, no scan_done.
- Tick while busy (cfg_period≠0): tick dropped, err_overrun set.
- sw_trig while busy: silently ignored.
- FSM states:
  - IDLE -> ISSUE on start; busy=1 from next cycle. Channel pointer = lowest set bit of latched mask.
  - ISSUE: cmd_valid=1; cmd_data = cfg_ctrl_word with bits [CH_LSB+:$clog2(N_CH)] = pointer. cmd_data is held stable until cmd_ready. On handshake -> WAIT_RSP with timeout counter cleared.
  - WAIT_RSP:
    - On rsp_valid: res_data[ptr] <= rsp_data, res_valid[ptr] <= 1.
    - If a higher set bit remains: pointer advances to it, go to ISSUE (cmd_valid next cycle).
    - Else: IDLE with scan_done=1 and busy=0 in the following cycle.
    - Timeout when counter reaches RSP_TIMEOUT-1 without rsp_valid: err_timeout set, scan aborted, go to IDLE, no scan_done.
- Channels are visited strictly ascending, with one outstanding command maximum.
- rsp_valid outside WAIT_RSP (e.g. a late response) is dropped.
- Simultaneous set and clear on the same cycle: set wins, for both res_valid/res_clr and error flags/err_clr.
- Asynchronous reset mid-scan returns to IDLE immediately; cmd_valid drops without handshake.
- Minimum scan cost per channel: 1 ISSUE cycle + engine latency + 1 cycle.

Test Plan:
- Single-shot scan: mask=4'b1011, ctrl_word=10'h000, sw_trig; engine replies 10'h101/10'h102/10'h108 -> cmd_data 10'h000, 10'h008, 10'h018 in order; res_valid=4'b1011; one scan_done; busy low afterwards.
- Periodic scan: cfg_period=200, enable=1, mask=4'b0001, engine latency 20 -> scan_done every 200 cycles; err_overrun stays 0. Then set cfg_period=10 -> err_overrun=1 within one period.
- Backpressure: hold cmd_ready=0 for 15 cycles -> cmd_valid and cmd_data stable throughout; exactly one command is accepted.
- Timeout: RSP_TIMEOUT=64, engine never responds -> err_timeout=1 64 cycles after handshake; no scan_done; a later rsp_valid does not change res_*. err_clr clears the flag.
- Boundary: mask=0 with sw_trig -> no cmd_valid. res_clr[0] coincident with ch0 write -> res_valid[0]=1. Assert rst_n low mid-WAIT_RSP -> all outputs 0 asynchronously.
